prog_loader: RTL

- Program-memory front end that sits directly upstream of the TD4-style CPU core.
- Accepts a 16-byte program over a valid/ready byte stream and stores it in an internal 16x8 register file.
- Serves the core's combinational fetch port (4-bit address in, 8-bit op out).
- Holds the core in reset until a load completes or a run is requested.

---
 rtl/prog_loader.sv | 113 +++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Program-memory front end for the TD4-style core: loads a DEPTH-byte program over a
// valid/ready stream, serves the combinational fetch port and holds the core in reset.
// Optional trailing checksum byte is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          run_req,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [DW-1:0] fetch_op,
  output logic          cpu_rst,
  output logic          loading,
  output logic [AW:0]   byte_cnt,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic          accept;

`ifdef PROG_LOADER_CHECKSUM_EN
  // The byte arriving when byte_cnt==DEPTH is the checksum and is never stored.
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH);
  logic [DW-1:0] sum;
  logic [DW-1:0] sum_next;

  assign sum_next = sum + in_data;
`else
  localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

  assign err = 1'b0;
`endif

  // in_ready lags the state by a cycle, so the state check keeps the stale cycle after LOAD inert.
  assign accept   = (state == LOAD) && in_ready && in_valid && !start;
  assign fetch_op = mem[fetch_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_cnt <= '0;
      cpu_rst  <= 1'b1;
      in_ready <= 1'b0;
      loading  <= 1'b0;
      done     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      sum <= '0;
      err <= 1'b0;
`endif
    end else begin
      in_ready <= (state == LOAD);
      loading  <= (state == LOAD);
      cpu_rst  <= (state != RUN);
      // cpu_rst still holds last cycle's "not running", so this fires once per RUN entry.
      done     <= (state == RUN) && cpu_rst;

      if (start) begin
        state    <= LOAD;
        byte_cnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum <= '0;
        err <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (run_req) begin
              state <= RUN;
            end
          end
          LOAD: begin
            if (accept) begin
              byte_cnt <= byte_cnt + 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
              if (byte_cnt == LAST) begin
                if (sum_next == '0) begin
                  state <= RUN;
                end else begin
                  state <= IDLE;
                  err   <= 1'b1;
                end
              end else begin
                mem[byte_cnt[AW-1:0]] <= in_data;
                sum                   <= sum_next;
              end
`else
              mem[byte_cnt[AW-1:0]] <= in_data;
              if (byte_cnt == LAST) begin
                state <= RUN;
              end
`endif
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
